// File: rtl/infernet_net_pkg.sv
// Shared network constants, transmit state encoding and address byte helper
// used by the inference engine's Ethernet/IP paths.
package infernet_net_pkg;

   localparam logic [15:0] ETH_HDR_SIZE_BYTES = 16'd14;
   localparam logic [15:0] IP_HDR_SIZE_BYTES  = 16'd24;
   localparam logic [15:0] USER_DATA_BYTES    = 16'd785;
   localparam logic [15:0] RESULT_BYTES       = 16'd2;
   localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL         = 8'h46;
   localparam logic [15:0] IP_TOTAL_LENGTH    = 16'd26;
   localparam logic [7:0]  IP_TTL             = 8'h40;
   localparam logic [7:0]  IP_PROTOCOL        = 8'hFD;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      SEND_ETH_HDR = 2'd1,
      SEND_IP_HDR  = 2'd2,
      SEND_PAYLOAD = 2'd3
   } tx_state_t;

   // Header byte k of an address field carries address bits [8k+7:8k].
   function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
      return addr[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/counter_sync_reset.sv
// Up-counter with synchronous clear (clear wins over increment) and
// asynchronous active-low reset.
module counter_sync_reset #(
   parameter int SIZE = 16
) (
   input  logic            ACLK,
   input  logic            ARESET,
   input  logic            clear,
   input  logic            incr,
   output logic [SIZE-1:0] count
);

   logic [SIZE-1:0] count_q;
   logic [SIZE-1:0] count_d;

   // Next count: clear, increment or hold.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (incr) begin
         count_d = count_q + SIZE'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ip_packet_tx.sv
// Result transmitter: turns each accepted inference result into a 40-byte
// Ethernet/IPv4 frame streamed byte-wise over AXI-Stream to the MAC.
module ip_packet_tx
   import infernet_net_pkg::*;
(
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [31:0] ACCELERATOR_IP_ADDRESS,
   input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
   input  logic [31:0] DST_IP_ADDRESS,
   input  logic [47:0] DST_MAC_ADDRESS,
   input  logic [7:0]  RESULT_META,
   input  logic [7:0]  RESULT_CLASS,
   input  logic        RESULT_VALID,
   output logic        RESULT_READY,
   output logic [7:0]  MAC_DATA_IN,
   output logic        MAC_DATA_VALID,
   input  logic        MAC_DATA_READY,
   output logic        MAC_DATA_LAST,
   output logic        BUSY
);

   tx_state_t   state_q, state_d;
   logic [15:0] byte_cnt;
   logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
   logic [31:0] dst_ip_q, dst_ip_d, src_ip_q, src_ip_d;
   logic [7:0]  meta_q, meta_d, class_q, class_d;
   logic [7:0]  tx_byte;
   logic        accept;
   logic        xfer;

   assign accept = RESULT_VALID && (state_q == IDLE);
   assign xfer   = MAC_DATA_VALID && MAC_DATA_READY;

   // Section sequencing; each section ends on the transfer of its last byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = SEND_ETH_HDR;
            else        state_d = IDLE;
         end
         SEND_ETH_HDR: begin
            if (xfer && (byte_cnt == ETH_HDR_SIZE_BYTES - 16'd1)) state_d = SEND_IP_HDR;
            else                                                   state_d = SEND_ETH_HDR;
         end
         SEND_IP_HDR: begin
            if (xfer && (byte_cnt == IP_HDR_SIZE_BYTES - 16'd1)) state_d = SEND_PAYLOAD;
            else                                                  state_d = SEND_IP_HDR;
         end
         SEND_PAYLOAD: begin
            if (xfer && (byte_cnt == RESULT_BYTES - 16'd1)) state_d = IDLE;
            else                                             state_d = SEND_PAYLOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the frame contents only on accept so later input changes are ignored.
   always_comb begin
      dst_mac_d = dst_mac_q;
      src_mac_d = src_mac_q;
      dst_ip_d  = dst_ip_q;
      src_ip_d  = src_ip_q;
      meta_d    = meta_q;
      class_d   = class_q;
      if (accept) begin
         dst_mac_d = DST_MAC_ADDRESS;
         src_mac_d = ACCELERATOR_MAC_ADDRESS;
         dst_ip_d  = DST_IP_ADDRESS;
         src_ip_d  = ACCELERATOR_IP_ADDRESS;
         meta_d    = RESULT_META;
         class_d   = RESULT_CLASS;
      end else begin
         dst_mac_d = dst_mac_q;
      end
   end

   // State register.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched frame contents; no reset needed as they are only read mid-frame.
   always_ff @(posedge ACLK) begin
      dst_mac_q <= dst_mac_d;
      src_mac_q <= src_mac_d;
      dst_ip_q  <= dst_ip_d;
      src_ip_q  <= src_ip_d;
      meta_q    <= meta_d;
      class_q   <= class_d;
   end

   counter_sync_reset #(.SIZE(16)) u_byte_cnt (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .clear  (state_d != state_q),
      .incr   (xfer),
      .count  (byte_cnt)
   );

   // Byte selection from state and in-section offset.
   always_comb begin
      tx_byte = 8'h00;
      case (state_q)
         SEND_ETH_HDR: begin
            if (byte_cnt < 16'd6)        tx_byte = addr_byte(dst_mac_q, 3'(byte_cnt));
            else if (byte_cnt < 16'd12)  tx_byte = addr_byte(src_mac_q, 3'(byte_cnt - 16'd6));
            else if (byte_cnt == 16'd12) tx_byte = ETHERTYPE_IPV4[15:8];
            else if (byte_cnt == 16'd13) tx_byte = ETHERTYPE_IPV4[7:0];
            else                         tx_byte = 8'h00;
         end
         SEND_IP_HDR: begin
            case (byte_cnt)
               16'd0:  tx_byte = IP_VER_IHL;
               16'd2:  tx_byte = IP_TOTAL_LENGTH[15:8];
               16'd3:  tx_byte = IP_TOTAL_LENGTH[7:0];
               16'd8:  tx_byte = IP_TTL;
               16'd9:  tx_byte = IP_PROTOCOL;
               16'd16, 16'd17, 16'd18, 16'd19:
                  tx_byte = addr_byte({16'h0000, src_ip_q}, 3'(byte_cnt - 16'd16));
               16'd20, 16'd21, 16'd22, 16'd23:
                  tx_byte = addr_byte({16'h0000, dst_ip_q}, 3'(byte_cnt - 16'd20));
               default: tx_byte = 8'h00;
            endcase
         end
         SEND_PAYLOAD: begin
            if (byte_cnt == 16'd0)      tx_byte = meta_q;
            else if (byte_cnt == 16'd1) tx_byte = class_q;
            else                        tx_byte = 8'h00;
         end
         default: tx_byte = 8'h00;
      endcase
   end

   assign RESULT_READY   = (state_q == IDLE);
   assign BUSY           = (state_q != IDLE);
   assign MAC_DATA_VALID = (state_q != IDLE);
   assign MAC_DATA_IN    = tx_byte;
   assign MAC_DATA_LAST  = (state_q == SEND_PAYLOAD) && (byte_cnt == RESULT_BYTES - 16'd1);

endmodule

// File: tb/tb_ip_packet_tx.sv
// Bench for ip_packet_tx: frame-level model checked every cycle plus a
// hand-written golden frame.
`timescale 1ns/1ps
module tb_ip_packet_tx;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] ACCELERATOR_IP_ADDRESS;
   logic [47:0] ACCELERATOR_MAC_ADDRESS;
   logic [31:0] DST_IP_ADDRESS;
   logic [47:0] DST_MAC_ADDRESS;
   logic [7:0]  RESULT_META;
   logic [7:0]  RESULT_CLASS;
   logic        RESULT_VALID;
   logic        RESULT_READY;
   logic [7:0]  MAC_DATA_IN;
   logic        MAC_DATA_VALID;
   logic        MAC_DATA_READY;
   logic        MAC_DATA_LAST;
   logic        BUSY;

   ip_packet_tx dut (
      .ACLK                    (ACLK),
      .ARESET                  (ARESET),
      .ACCELERATOR_IP_ADDRESS  (ACCELERATOR_IP_ADDRESS),
      .ACCELERATOR_MAC_ADDRESS (ACCELERATOR_MAC_ADDRESS),
      .DST_IP_ADDRESS          (DST_IP_ADDRESS),
      .DST_MAC_ADDRESS         (DST_MAC_ADDRESS),
      .RESULT_META             (RESULT_META),
      .RESULT_CLASS            (RESULT_CLASS),
      .RESULT_VALID            (RESULT_VALID),
      .RESULT_READY            (RESULT_READY),
      .MAC_DATA_IN             (MAC_DATA_IN),
      .MAC_DATA_VALID          (MAC_DATA_VALID),
      .MAC_DATA_READY          (MAC_DATA_READY),
      .MAC_DATA_LAST           (MAC_DATA_LAST),
      .BUSY                    (BUSY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         accepts = 0;
   int         frames_done = 0;
   int         xfer_cnt = 0;
   int         cyc = 0;
   int         accept_cyc = 0;
   int         rdy_mode = 0;
   logic [7:0] cap [40];
   logic [7:0] last_frame [40];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;

   logic [7:0] golden [40] = '{
      8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA,
      8'hBB, 8'hCC, 8'h08, 8'h00, 8'h46, 8'h00, 8'h00, 8'h1A, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h40, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h01, 8'h00, 8'h00, 8'h0A, 8'h02, 8'h00, 8'h00, 8'h0A, 8'h05, 8'h07
   };

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Frame model: 14 Ethernet bytes, 24 IP bytes, 2 payload bytes, LAST on the 40th.
   function automatic void push_frame(input logic [47:0] dmac, input logic [47:0] smac,
                                      input logic [31:0] dip, input logic [31:0] sip,
                                      input logic [7:0] meta, input logic [7:0] cls);
      logic [7:0] f [40];
      exp_t       e;
      for (int i = 0; i < 40; i++) f[i] = 8'h00;
      for (int k = 0; k < 6; k++) begin
         f[k]     = 8'((dmac >> (8 * k)) & 48'hFF);
         f[6 + k] = 8'((smac >> (8 * k)) & 48'hFF);
      end
      f[12] = 8'h08;
      f[14] = 8'h46;
      f[17] = 8'd26;
      f[22] = 8'h40;
      f[23] = 8'hFD;
      for (int k = 0; k < 4; k++) begin
         f[30 + k] = 8'((sip >> (8 * k)) & 32'hFF);
         f[34 + k] = 8'((dip >> (8 * k)) & 32'hFF);
      end
      f[38] = meta;
      f[39] = cls;
      for (int i = 0; i < 40; i++) begin
         e.data = f[i];
         e.last = (i == 39);
         exp_q.push_back(e);
      end
   endfunction

   // Compare process: checks the DUT against the model on every cycle.
   always @(negedge ACLK) begin
      logic idle_m;
      exp_t e;
      cyc++;
      if (!ARESET) begin
         exp_q.delete();
         xfer_cnt   = 0;
         prev_stall = 1'b0;
         check("rst_valid", 64'(MAC_DATA_VALID), 64'd0);
         check("rst_last", 64'(MAC_DATA_LAST), 64'd0);
      end else begin
         idle_m = (exp_q.size() == 0);
         check("ready", 64'(RESULT_READY), 64'(idle_m));
         check("busy", 64'(BUSY), 64'(!idle_m));
         check("valid", 64'(MAC_DATA_VALID), 64'(!idle_m));
         if (prev_stall && MAC_DATA_VALID) begin
            check("stall_data", 64'(MAC_DATA_IN), 64'(prev_data));
            check("stall_last", 64'(MAC_DATA_LAST), 64'(prev_last));
         end
         prev_stall = MAC_DATA_VALID && !MAC_DATA_READY;
         prev_data  = MAC_DATA_IN;
         prev_last  = MAC_DATA_LAST;
         if (idle_m) begin
            check("idle_last", 64'(MAC_DATA_LAST), 64'd0);
            if (RESULT_VALID) begin
               push_frame(DST_MAC_ADDRESS, ACCELERATOR_MAC_ADDRESS, DST_IP_ADDRESS,
                          ACCELERATOR_IP_ADDRESS, RESULT_META, RESULT_CLASS);
               accepts++;
               accept_cyc = cyc;
            end
         end else if (MAC_DATA_READY) begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d", xfer_cnt), 64'(MAC_DATA_IN), 64'(e.data));
            check($sformatf("last%0d", xfer_cnt), 64'(MAC_DATA_LAST), 64'(e.last));
            cap[xfer_cnt] = MAC_DATA_IN;
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               last_frame  = cap;
               frames_done++;
               xfer_cnt    = 0;
               if (rdy_mode == 0) check("latency", 64'(cyc - accept_cyc), 64'd40);
            end
         end
      end
   end

   // Downstream ready: constant high or pseudo-random backpressure.
   initial begin
      MAC_DATA_READY = 1'b1;
      forever begin
         @(posedge ACLK);
         #1;
         MAC_DATA_READY = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   task automatic set_inputs(input logic [7:0] cls);
      DST_MAC_ADDRESS         = 48'h665544332211;
      DST_IP_ADDRESS          = 32'h0A000002;
      ACCELERATOR_MAC_ADDRESS = 48'hCCBBAA998877;
      ACCELERATOR_IP_ADDRESS  = 32'h0A000001;
      RESULT_META             = 8'h05;
      RESULT_CLASS            = cls;
   endtask

   task automatic scramble_inputs();
      DST_MAC_ADDRESS         = 48'hDEADBEEF0102;
      DST_IP_ADDRESS          = 32'hC0A80105;
      ACCELERATOR_MAC_ADDRESS = 48'h0123456789AB;
      ACCELERATOR_IP_ADDRESS  = 32'hFFEEDDCC;
      RESULT_META             = 8'hE1;
      RESULT_CLASS            = 8'hE2;
   endtask

   task automatic send(input logic [7:0] cls);
      int target;
      target = accepts + 1;
      @(posedge ACLK);
      #1;
      set_inputs(cls);
      RESULT_VALID = 1'b1;
      for (int i = 0; i < 200 && accepts < target; i++) @(posedge ACLK);
      check("accept_timeout", 64'(accepts >= target), 64'd1);
      #1;
      RESULT_VALID = 1'b0;
      scramble_inputs();
   endtask

   task automatic wait_frames(input int n);
      for (int i = 0; i < 3000 && frames_done < n; i++) @(posedge ACLK);
      check("frame_timeout", 64'(frames_done >= n), 64'd1);
   endtask

   task automatic compare_golden(input string tag, input logic [7:0] cls);
      logic [7:0] want;
      for (int i = 0; i < 40; i++) begin
         want = (i == 39) ? cls : golden[i];
         check($sformatf("%s_b%0d", tag, i), 64'(last_frame[i]), 64'(want));
      end
   endtask

   initial begin
      int target;
      ARESET       = 1'b0;
      RESULT_VALID = 1'b0;
      scramble_inputs();
      repeat (3) @(posedge ACLK);
      #1;
      check("reset_valid", 64'(MAC_DATA_VALID), 64'd0);
      check("reset_last", 64'(MAC_DATA_LAST), 64'd0);
      check("reset_data", 64'(MAC_DATA_IN), 64'h00);
      check("reset_busy", 64'(BUSY), 64'd0);
      ARESET = 1'b1;
      @(posedge ACLK);
      #1;
      check("ready_after_reset", 64'(RESULT_READY), 64'd1);

      // Frame 1: ready held high.
      send(8'h07);
      wait_frames(1);
      compare_golden("f1", 8'h07);

      // Frame 2: random backpressure, same byte stream expected.
      rdy_mode = 1;
      send(8'h07);
      wait_frames(2);
      compare_golden("f2", 8'h07);
      rdy_mode = 0;

      // Pulse while busy is ignored; held valid is taken as soon as ready returns.
      send(8'h07);
      repeat (5) @(posedge ACLK);
      #1;
      set_inputs(8'h03);
      RESULT_VALID = 1'b1;
      @(posedge ACLK);
      #1;
      RESULT_VALID = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      RESULT_VALID = 1'b1;
      target = 4;
      for (int i = 0; i < 200 && accepts < target; i++) @(posedge ACLK);
      check("held_accept", 64'(accepts), 64'd4);
      #1;
      RESULT_VALID = 1'b0;
      check("frames_before_held", 64'(frames_done), 64'd3);
      compare_golden("f3", 8'h07);
      wait_frames(4);
      check("f4_meta", 64'(last_frame[38]), 64'h05);
      check("f4_class", 64'(last_frame[39]), 64'h03);
      repeat (5) @(posedge ACLK);
      check("no_extra_accept", 64'(accepts), 64'd4);

      // Reset at byte 20 aborts the frame without LAST.
      send(8'h07);
      for (int i = 0; i < 200 && xfer_cnt < 20; i++) @(posedge ACLK);
      check("reach_byte20", 64'(xfer_cnt >= 20), 64'd1);
      #1;
      ARESET = 1'b0;
      #1;
      check("abort_valid", 64'(MAC_DATA_VALID), 64'd0);
      check("abort_last", 64'(MAC_DATA_LAST), 64'd0);
      check("abort_busy", 64'(BUSY), 64'd0);
      check("abort_data", 64'(MAC_DATA_IN), 64'h00);
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b1;
      check("abort_not_counted", 64'(frames_done), 64'd4);
      send(8'h07);
      wait_frames(5);
      compare_golden("f5", 8'h07);

      repeat (3) @(posedge ACLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
